mem_spi_flash_responder: RTL
============================

// Module: mem_spi_flash_responder
// PURPOSE
//  SPI/QSPI flash target (responder) model; the far end of mem_spi_controller on uio[3:0].
//  - Decodes a subset of flash commands and serves them from a byte-wide synchronous memory port.
//  - Used as the synthesizable flash stand-in for FPGA bring-up and for closed-loop benches of the
//    transaction FSM and controller.
// PARAMETERS
//  MEM_AW      16   backing-memory address bits; the 24-bit SPI address is taken modulo 2^MEM_AW
//  PROG_CYCLES 64   clk cycles WIP stays set after a program or WRSR completes
// PORTS
//  clk         in   1        system clock; must be at least 8x sclk
//  rst_n       in   1        asynchronous, active-low reset
//  sclk        in   1        SPI clock from the host, mode 0, asynchronous to clk
//  cs_n        in   1        chip select from the host, active low
//  io_in       in   4        io[0]=MOSI/IO0 ... io[3]=IO3
//  io_out      out  4        driven data; io[1]=MISO in single mode
//  io_oe       out  4        per-pin output enable, 1=drive
//  mem_addr    out  MEM_AW   backing-memory byte address
//  mem_re      out  1        read strobe; mem_rdata is valid exactly 1 clk later
//  mem_rdata   in   8        read data
//  mem_we      out  1        1-clk write strobe
//  mem_wdata   out  8        write data
//  status      out  8        debug: {6'b0 ... } = SR1 bits {WEL,WIP} in [1:0]
// BEHAVIOUR
//  Reset: all outputs 0; SR1 (WIP, WEL) = 0; SR2.QE = 0; FSM = IDLE.
//  Sync: sclk, cs_n and io_in each pass a 2-flop synchronizer.
//  - rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
//  - Sample on rise, MSB first. Update io_out on fall, <=3 clk after the sclk edge.
//  cs_n rise (sync), at any state: -> IDLE. io_oe = 0 next clk. Partial byte discarded.
//  - A pending write-class command commits only if its byte count is complete.
//  FSM states:
//  - IDLE -> CMD on cs_n fall.
//  - CMD: 8 bits on io[0]. Decode:
//    - 06 WREN: set WEL at cs_n rise.
//    - 04 WRDI: clear WEL at cs_n rise.
//    - 05 RDSR1 -> STAT, output {6'b0, WEL, WIP}.
//    - 35 RDSR2 -> STAT, output {6'b0, QE, 1'b0}.
//    - 01 WRSR -> WDATA. Needs WEL & ~WIP. 2 bytes: SR1 ignored; SR2 bit1 -> QE.
//    - 03 READ -> ADDR -> RD1.
//    - 6B QREAD -> ADDR -> DUMMY(8 sclk) -> RD4. Needs QE, else IGNORE.
//    - 02 PP -> ADDR -> WDATA. Needs WEL & ~WIP, else IGNORE.
//    - Any other opcode, or any command while WIP=1 except 05/35 -> IGNORE.
//  - ADDR: 24 bits on io[0]; the address counter loads on the 24th rise.
//  - STAT: repeats the selected register every 8 sclk until cs_n rises.
//  - RD1: MISO=io[1], io_oe=4'b0010; 1 bit per fall.
//  - RD4: io_oe=4'b1111; nibble per fall, high nibble first.
//  - Reads: address increments per byte, wraps at 2^MEM_AW.
//    - Prefetch: mem_re pulses 1 clk when the address loads, and again when the last bit/nibble of the
//      current byte is launched; next byte latched into the shift register before the following fall.
//  - WDATA (PP): each complete byte -> mem_we 1 clk, mem_addr = current addr.
//    - Address increments within page only: addr[7:0] wraps, addr[MEM_AW-1:8] fixed.
//    - A PP with >=1 byte starts WIP at cs_n rise.
//  - WIP timer: loads PROG_CYCLES at commit, counts down.
//    - At 0: clear WIP and WEL.
//    - WRSR commit also starts WIP.
//  - IGNORE: io_oe=0, no memory strobes, until cs_n rise.
//  Simultaneous: cs_n rise wins over a coincident sclk edge; no sample is taken on that clk.
//  mem_we and mem_re are never high in the same clk.
// STRUCTURE
//  Package mem_spi_pkg: opcode localparams (CMD_WREN ... CMD_QREAD), FSM state enum, SR bit indices.
//  - Shared with mem_transaction_fsm.
//  Sub-module mem_spi_edge_sync: 2-flop synchronizer + rise/fall detect for sclk and cs_n.
//  Everything else lives in this module: FSM, shift register, address counter, WIP timer.
// TESTING
//  1. READ 03 000010, memory[0x10..0x12]=A5,3C,FF, 24 sclk of data -> MISO bytes A5,3C,FF; io_oe=0010.
//  2. QREAD 6B with QE=0 -> io_oe stays 0.
//     Then WREN; WRSR 00,02; wait PROG_CYCLES; RDSR2 -> 02.
//     Then 6B 00FFFF, 8 dummy -> nibbles from mem[FFFF], then wrap to mem[0000].
//  3. PP without WREN -> mem_we never asserts.
//     WREN; PP 0001FE, D0,D1,D2 -> writes 01FE=D0, 01FF=D1, 0100=D2 (page wrap).
//  4. RDSR1 polled during a program -> 03 while busy.
//     Exactly PROG_CYCLES clk after cs_n rise -> 00 (WIP and WEL both cleared).
//  5. cs_n deasserted after 5 bits of WREN -> WEL stays 0.
//     cs_n raised mid-RD4 byte -> io_oe=0 within 3 clk; next CMD decodes cleanly.
//  6. rst_n asserted mid-PP -> all outputs 0 immediately; QE, WEL, WIP = 0.

Source files
------------

// File: rtl/mem_spi_pkg.sv
// Shared SPI flash definitions: opcodes, status-register bit positions and the responder FSM states.
// Also used by mem_transaction_fsm, so opcode values here are the single source of truth.
package mem_spi_pkg;

    localparam logic [7:0] CMD_WRSR  = 8'h01;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR1 = 8'h05;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR2 = 8'h35;
    localparam logic [7:0] CMD_QREAD = 8'h6B;

    localparam int unsigned SR1_WIP = 0;
    localparam int unsigned SR1_WEL = 1;
    localparam int unsigned SR2_QE  = 1;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StStat,
        StRd1,
        StRd4,
        StWdata,
        StWait,
        StIgnore
    } spi_state_e;

endpackage

// File: rtl/mem_spi_edge_sync.sv
// Brings the host's sclk, cs_n and io pins into the clk domain and flags sclk/cs_n edges.
// io is delayed by the same two flops as sclk so a detected rise sees the matching data bit.
module mem_spi_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_rise,
    output logic       cs_fall,
    output logic [3:0] io_s
);

    logic       sclk_m, sclk_s, sclk_q;
    logic       cs_m, cs_s, cs_q;
    logic [3:0] io_m;

    // cs_n chain resets high so a deselected host never looks like a fresh select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_q <= 1'b0;
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
            cs_q   <= 1'b1;
            io_m   <= '0;
            io_s   <= '0;
        end else begin
            sclk_m <= sclk;
            sclk_s <= sclk_m;
            sclk_q <= sclk_s;
            cs_m   <= cs_n;
            cs_s   <= cs_m;
            cs_q   <= cs_s;
            io_m   <= io_in;
            io_s   <= io_m;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

endmodule

// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI flash target serving READ, QREAD, PP, WRSR and status commands from a byte-wide
// synchronous memory port; all SPI signals are oversampled by clk.
module mem_spi_flash_responder
    import mem_spi_pkg::*;
#(
    parameter int unsigned MEM_AW      = 16,
    parameter int unsigned PROG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic [7:0]        status
);

    localparam int unsigned TW = $clog2(PROG_CYCLES + 1);

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [3:0]        io_s;
    spi_state_e        state;
    logic [4:0]        bit_cnt;
    logic [MEM_AW-2:0] shift;
    logic [MEM_AW-1:0] rx_word, addr;
    logic [7:0]        rx_byte, cmd, tx_sr, data_buf, cur_byte, sr1, sr2;
    logic [2:0]        rd_bit;
    logic [1:0]        wr_cnt;
    logic              wrsr_qe, fetch_q, wel, wip, qe, unused_io;
    logic [TW-1:0]     timer;

    mem_spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .io_in     (io_in),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .io_s      (io_s)
    );

    // Only MEM_AW address bits are kept, so the upper SPI address bits simply shift out.
    assign rx_word   = {shift, io_s[0]};
    assign rx_byte   = rx_word[7:0];
    assign unused_io = ^io_s[3:1];

    always_comb begin
        sr1          = '0;
        sr1[SR1_WEL] = wel;
        sr1[SR1_WIP] = wip;
        sr2          = '0;
        sr2[SR2_QE]  = qe;
    end

    assign cur_byte = (state == StStat) ? ((cmd == CMD_RDSR2) ? sr2 : sr1) : data_buf;
    assign status   = sr1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            shift     <= '0;
            cmd       <= '0;
            tx_sr     <= '0;
            data_buf  <= '0;
            rd_bit    <= '0;
            addr      <= '0;
            wr_cnt    <= '0;
            wrsr_qe   <= 1'b0;
            fetch_q   <= 1'b0;
            wel       <= 1'b0;
            wip       <= 1'b0;
            qe        <= 1'b0;
            timer     <= '0;
            io_out    <= '0;
            io_oe     <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            fetch_q <= mem_re;
            if (fetch_q) data_buf <= mem_rdata;

            if (wip) begin
                if (timer <= TW'(1)) begin
                    wip   <= 1'b0;
                    wel   <= 1'b0;
                    timer <= '0;
                end else begin
                    timer <= timer - TW'(1);
                end
            end

            // Deselect ends every transaction; only fully received commands commit here.
            if (cs_rise) begin
                state  <= StIdle;
                io_oe  <= '0;
                io_out <= '0;
                if (state == StWait && cmd == CMD_WREN) wel <= 1'b1;
                if (state == StWait && cmd == CMD_WRDI) wel <= 1'b0;
                if (state == StWdata && ((cmd == CMD_PP && wr_cnt != 2'd0) ||
                                         (cmd == CMD_WRSR && wr_cnt >= 2'd2))) begin
                    wip   <= 1'b1;
                    timer <= TW'(PROG_CYCLES);
                    if (cmd == CMD_WRSR) qe <= wrsr_qe;
                end
            end else begin
                unique case (state)
                    StIdle: if (cs_fall) begin
                        state   <= StCmd;
                        bit_cnt <= '0;
                    end
                    StCmd: if (sclk_rise) begin
                        shift   <= rx_word[MEM_AW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            cmd     <= rx_byte;
                            bit_cnt <= '0;
                            rd_bit  <= '0;
                            wr_cnt  <= '0;
                            if (wip && rx_byte != CMD_RDSR1 && rx_byte != CMD_RDSR2) begin
                                state <= StIgnore;
                            end else begin
                                case (rx_byte)
                                    CMD_WREN, CMD_WRDI:   state <= StWait;
                                    CMD_RDSR1, CMD_RDSR2: begin
                                        state <= StStat;
                                        io_oe <= 4'b0010;
                                    end
                                    CMD_WRSR:  state <= wel ? StWdata : StIgnore;
                                    CMD_READ:  state <= StAddr;
                                    CMD_QREAD: state <= qe ? StAddr : StIgnore;
                                    CMD_PP:    state <= wel ? StAddr : StIgnore;
                                    default:   state <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StAddr: if (sclk_rise) begin
                        shift   <= rx_word[MEM_AW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            addr    <= rx_word;
                            if (cmd == CMD_PP) begin
                                state <= StWdata;
                            end else begin
                                mem_re   <= 1'b1;
                                mem_addr <= rx_word;
                                if (cmd == CMD_READ) begin
                                    state <= StRd1;
                                    io_oe <= 4'b0010;
                                end else begin
                                    state <= StDummy;
                                end
                            end
                        end
                    end
                    StDummy: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            state <= StRd4;
                            io_oe <= 4'b1111;
                        end
                    end
                    StStat, StRd1: if (sclk_fall) begin
                        rd_bit <= rd_bit + 3'd1;
                        if (rd_bit == 3'd0) begin
                            io_out <= {2'b00, cur_byte[7], 1'b0};
                            tx_sr  <= {cur_byte[6:0], 1'b0};
                            if (state == StRd1) addr <= addr + MEM_AW'(1);
                        end else begin
                            io_out <= {2'b00, tx_sr[7], 1'b0};
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                        end
                        // Fetch the next byte while its predecessor's last bit is on the wire.
                        if (rd_bit == 3'd7 && state == StRd1) begin
                            mem_re   <= 1'b1;
                            mem_addr <= addr;
                        end
                    end
                    StRd4: if (sclk_fall) begin
                        rd_bit <= {2'b00, ~rd_bit[0]};
                        if (!rd_bit[0]) begin
                            io_out <= cur_byte[7:4];
                            tx_sr  <= {cur_byte[3:0], 4'h0};
                            addr   <= addr + MEM_AW'(1);
                        end else begin
                            io_out   <= tx_sr[7:4];
                            mem_re   <= 1'b1;
                            mem_addr <= addr;
                        end
                    end
                    StWdata: if (sclk_rise) begin
                        shift   <= rx_word[MEM_AW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (wr_cnt != 2'd3) wr_cnt <= wr_cnt + 2'd1;
                            if (cmd == CMD_PP) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= rx_byte;
                                addr      <= {addr[MEM_AW-1:8], addr[7:0] + 8'd1};
                            end else if (wr_cnt == 2'd1) begin
                                wrsr_qe <= rx_byte[SR2_QE];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
